// File: rtl/asm_seq_ctrl_pkg.sv
// Shared types for the ASM sequence controller: state and exit-path encodings,
// plus the mapping from a completing state to the path it reports.
package asm_seq_ctrl_pkg;

   typedef enum logic [2:0] {
      S_0 = 3'b000,
      S_1 = 3'b001,
      S_2 = 3'b010,
      S_3 = 3'b011,
      S_4 = 3'b100,
      S_5 = 3'b101,
      S_6 = 3'b110,
      S_7 = 3'b111
   } state_t;

   typedef enum logic [1:0] {
      P_NONE = 2'b00,
      P_F    = 2'b01,
      P_E    = 2'b10,
      P_W    = 2'b11
   } path_t;

   function automatic path_t exit_path(input state_t s);
      case (s)
         S_3:     return P_F;
         S_5:     return P_E;
         S_7:     return P_W;
         default: return P_NONE;
      endcase
   endfunction

endpackage

// File: rtl/onehot_dec_msb.sv
// One-hot decoder with MSB-first ordering: index i drives bit N-1-i.
// Indices at or beyond N decode to all zeros.
module onehot_dec_msb #(
   parameter int N = 8
) (
   input  logic [$clog2(N)-1:0] idx_i,
   output logic [N-1:0]         onehot_o
);

   localparam int IW = $clog2(N);

   always_comb begin
      // NOTE: default assignment first so no path through the block leaves onehot_o unassigned (no latch).
      onehot_o = '0;
      for (int i = 0; i < N; i++) begin
         if (idx_i == IW'(i)) onehot_o[N-1-i] = 1'b1;
      end
   end

endmodule

// File: rtl/asm_seq_ctrl.sv
// ASM-chart sequence controller: branches on x/y, F and E, dwells a programmable
// number of cycles in S_6, and reports a one-cycle done pulse with the exit path.
module asm_seq_ctrl
   import asm_seq_ctrl_pkg::*;
#(
   parameter int WAIT_W = 4,
   parameter int SEQ_W  = 8
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              en,
   input  logic              x,
   input  logic              y,
   input  logic              F,
   input  logic              E,
   input  logic [WAIT_W-1:0] wait_len,
   output state_t            state,
   output logic [7:0]        dec_out,
   output logic              busy,
   output logic              done,
   output path_t             path,
   output logic [WAIT_W-1:0] wait_cnt,
   output logic [SEQ_W-1:0]  seq_cnt
);

   localparam logic [SEQ_W-1:0] SEQ_MAX = '1;

   state_t            state_q;
   path_t             path_q;
   logic              done_q;
   logic [WAIT_W-1:0] wait_cnt_q;
   logic [SEQ_W-1:0]  seq_cnt_q;
   logic              completing;

   assign completing = en && (state_q == S_3 || state_q == S_5 || state_q == S_7);

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q    <= S_0;
         path_q     <= P_NONE;
         done_q     <= 1'b0;
         wait_cnt_q <= '0;
         seq_cnt_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
         done_q <= 1'b0;
         if (en) begin
            case (state_q)
               S_0: begin
                  case ({x, y})
                     2'b00:   state_q <= S_0;
                     2'b01:   state_q <= S_2;
                     default: state_q <= S_1;
                  endcase
               end
               S_1: state_q <= S_2;
               S_2: state_q <= F ? S_3 : S_4;
               S_4: begin
                  if (E) begin
                     state_q <= S_5;
                  end else begin
                     state_q    <= S_6;
                     wait_cnt_q <= wait_len;
                  end
               end
               S_6: begin
                  if (wait_cnt_q == '0) state_q <= S_7;
                  else                  wait_cnt_q <= wait_cnt_q - 1'b1;
               end
               default: state_q <= S_0;
            endcase

            if (completing) begin
               done_q <= 1'b1;
               path_q <= exit_path(state_q);
               if (seq_cnt_q != SEQ_MAX) seq_cnt_q <= seq_cnt_q + 1'b1;
            end
         end
      end
   end

   onehot_dec_msb #(.N(8)) u_dec (
      .idx_i    (state_q),
      .onehot_o (dec_out)
   );

   assign state    = state_q;
   assign busy     = (state_q != S_0);
   assign done     = done_q;
   assign path     = path_q;
   assign wait_cnt = wait_cnt_q;
   assign seq_cnt  = seq_cnt_q;

endmodule

// File: tb/tb_asm_seq_ctrl.sv
// Directed bench for asm_seq_ctrl: expected post-edge outputs are queued as each
// step is driven and popped for comparison one time unit after the clock edge.
module tb_asm_seq_ctrl;
   import asm_seq_ctrl_pkg::*;

   localparam int WAIT_W = 4;
   localparam int SEQ_W  = 2;

   typedef struct {
      state_t            st;
      logic              dn;
      path_t             p;
      logic [WAIT_W-1:0] wc;
      logic [SEQ_W-1:0]  sc;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_b, en, x, y, F, E;
   logic [WAIT_W-1:0] wait_len;
   state_t            state;
   logic [7:0]        dec_out;
   logic              busy, done;
   path_t             path;
   logic [WAIT_W-1:0] wait_cnt;
   logic [SEQ_W-1:0]  seq_cnt;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   asm_seq_ctrl #(.WAIT_W(WAIT_W), .SEQ_W(SEQ_W)) dut (
      .clk      (clk),
      .rst_b    (rst_b),
      .en       (en),
      .x        (x),
      .y        (y),
      .F        (F),
      .E        (E),
      .wait_len (wait_len),
      .state    (state),
      .dec_out  (dec_out),
      .busy     (busy),
      .done     (done),
      .path     (path),
      .wait_cnt (wait_cnt),
      .seq_cnt  (seq_cnt)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(state_t st, logic dn, path_t p, logic [WAIT_W-1:0] wc,
                               logic [SEQ_W-1:0] sc);
      exp_t e;
      e.st = st; e.dn = dn; e.p = p; e.wc = wc; e.sc = sc;
      return e;
   endfunction

   function automatic logic [7:0] exp_dec(state_t s);
      logic [7:0] top_bit;
      top_bit = 8'h80;
      return top_bit >> s;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_out(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         check({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      check({tag, ".state"},    32'(state),    32'(e.st));
      check({tag, ".dec_out"},  32'(dec_out),  32'(exp_dec(e.st)));
      check({tag, ".busy"},     32'(busy),     32'(e.st != S_0));
      check({tag, ".done"},     32'(done),     32'(e.dn));
      check({tag, ".path"},     32'(path),     32'(e.p));
      check({tag, ".wait_cnt"}, 32'(wait_cnt), 32'(e.wc));
      check({tag, ".seq_cnt"},  32'(seq_cnt),  32'(e.sc));
   endtask

   // Push the expected post-edge outputs, take one clock, then compare.
   task automatic step(input string tag, input exp_t e);
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_out(tag);
   endtask

   initial begin
      rst_b = 1'b0; en = 1'b0; x = 1'b0; y = 1'b0; F = 1'b0; E = 1'b0; wait_len = '0;

      // Reset values
      #12;
      sb.push_back(mk(S_0, 1'b0, P_NONE, 4'd0, 2'd0));
      check_out("reset");
      @(negedge clk) rst_b = 1'b1;
      @(posedge clk); #1;

      // S_0 -> S_1 -> S_2 -> S_3 -> S_0 via F
      en = 1'b1; x = 1'b1; y = 1'b0; F = 1'b1;
      step("f_s1", mk(S_1, 1'b0, P_NONE, 4'd0, 2'd0));
      x = 1'b0;
      step("f_s2", mk(S_2, 1'b0, P_NONE, 4'd0, 2'd0));
      step("f_s3", mk(S_3, 1'b0, P_NONE, 4'd0, 2'd0));
      step("f_done", mk(S_0, 1'b1, P_F, 4'd0, 2'd1));
      step("idle_no_done", mk(S_0, 1'b0, P_F, 4'd0, 2'd1));

      // Wait path with wait_len=3: four S_6 cycles
      y = 1'b1; F = 1'b0; E = 1'b0; wait_len = 4'd3;
      step("w_s2", mk(S_2, 1'b0, P_F, 4'd0, 2'd1));
      y = 1'b0;
      step("w_s4", mk(S_4, 1'b0, P_F, 4'd0, 2'd1));
      for (int i = 3; i >= 0; i--)
         step($sformatf("w_s6_%0d", i), mk(S_6, 1'b0, P_F, 4'(i), 2'd1));
      step("w_s7", mk(S_7, 1'b0, P_F, 4'd0, 2'd1));
      step("w_done", mk(S_0, 1'b1, P_W, 4'd0, 2'd2));

      // wait_len=0: single S_6 cycle, later wait_len change ignored
      y = 1'b1; wait_len = 4'd0;
      step("z_s2", mk(S_2, 1'b0, P_W, 4'd0, 2'd2));
      y = 1'b0;
      step("z_s4", mk(S_4, 1'b0, P_W, 4'd0, 2'd2));
      step("z_s6", mk(S_6, 1'b0, P_W, 4'd0, 2'd2));
      wait_len = 4'd15;
      step("z_s7", mk(S_7, 1'b0, P_W, 4'd0, 2'd2));
      step("z_done", mk(S_0, 1'b1, P_W, 4'd0, 2'd3));

      // Freeze in S_6 with wait_cnt=2; saturated seq_cnt stays at 3
      y = 1'b1; wait_len = 4'd3;
      step("h_s2", mk(S_2, 1'b0, P_W, 4'd0, 2'd3));
      y = 1'b0;
      step("h_s4", mk(S_4, 1'b0, P_W, 4'd0, 2'd3));
      step("h_s6_3", mk(S_6, 1'b0, P_W, 4'd3, 2'd3));
      step("h_s6_2", mk(S_6, 1'b0, P_W, 4'd2, 2'd3));
      en = 1'b0; wait_len = 4'd9;
      for (int i = 0; i < 5; i++)
         step($sformatf("h_frozen_%0d", i), mk(S_6, 1'b0, P_W, 4'd2, 2'd3));
      en = 1'b1;
      step("h_s6_1", mk(S_6, 1'b0, P_W, 4'd1, 2'd3));
      step("h_s6_0", mk(S_6, 1'b0, P_W, 4'd0, 2'd3));
      step("h_s7", mk(S_7, 1'b0, P_W, 4'd0, 2'd3));
      step("h_done", mk(S_0, 1'b1, P_W, 4'd0, 2'd3));

      // E branch
      y = 1'b1; E = 1'b1;
      step("e_s2", mk(S_2, 1'b0, P_W, 4'd0, 2'd3));
      y = 1'b0;
      step("e_s4", mk(S_4, 1'b0, P_W, 4'd0, 2'd3));
      step("e_s5", mk(S_5, 1'b0, P_W, 4'd0, 2'd3));
      step("e_done", mk(S_0, 1'b1, P_E, 4'd0, 2'd3));

      // Asynchronous reset during the S_6 dwell
      y = 1'b1; E = 1'b0; wait_len = 4'd3;
      step("r_s2", mk(S_2, 1'b0, P_E, 4'd0, 2'd3));
      y = 1'b0;
      step("r_s4", mk(S_4, 1'b0, P_E, 4'd0, 2'd3));
      step("r_s6", mk(S_6, 1'b0, P_E, 4'd3, 2'd3));
      rst_b = 1'b0;
      #1;
      sb.push_back(mk(S_0, 1'b0, P_NONE, 4'd0, 2'd0));
      check_out("r_async");
      step("r_held", mk(S_0, 1'b0, P_NONE, 4'd0, 2'd0));
      #2 rst_b = 1'b1;
      step("r_after", mk(S_0, 1'b0, P_NONE, 4'd0, 2'd0));

      // Five back-to-back sequences: seq_cnt 1,2,3,3,3
      x = 1'b1; F = 1'b1;
      for (int k = 0; k < 5; k++) begin
         y = k[0];
         step($sformatf("b%0d_s1", k), mk(S_1, 1'b0, k == 0 ? P_NONE : P_F, 4'd0, 2'(k > 3 ? 3 : k)));
         step($sformatf("b%0d_s2", k), mk(S_2, 1'b0, k == 0 ? P_NONE : P_F, 4'd0, 2'(k > 3 ? 3 : k)));
         step($sformatf("b%0d_s3", k), mk(S_3, 1'b0, k == 0 ? P_NONE : P_F, 4'd0, 2'(k > 3 ? 3 : k)));
         if (k == 4) begin
            x = 1'b0; y = 1'b0;
         end
         step($sformatf("b%0d_done", k), mk(S_0, 1'b1, P_F, 4'd0, 2'(k + 1 > 3 ? 3 : k + 1)));
      end
      step("b_idle", mk(S_0, 1'b0, P_F, 4'd0, 2'd3));

      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
